// File: rtl/decode_stage_pkg.sv
// Shared CPU definitions for the decode stage: opcodes, branch funct3 codes,
// the decoded control bundle and the decode FSM states.
package decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_imm;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [6:0] opcode;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Immediate in 32-bit sign-extended form; the stage widens it to XLEN.
  function automatic logic [31:0] imm32(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_JAL:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_IMM) || (op == OP_REG);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_REG);
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [31:0] ins);
    ctrl_t c;
    c          = CTRL_NOP;
    c.opcode   = ins[6:0];
    c.funct3   = ins[14:12];
    c.funct7b5 = ins[30];
    case (ins[6:0])
      OP_REG:           c.reg_write = 1'b1;
      OP_IMM:           begin c.reg_write = 1'b1; c.alu_imm = 1'b1; end
      OP_LOAD:          begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_imm = 1'b1; end
      OP_STORE:         begin c.mem_write = 1'b1; c.alu_imm = 1'b1; end
      OP_BRANCH:        c.branch = 1'b1;
      OP_JAL, OP_JALR:  begin c.reg_write = 1'b1; c.jump = 1'b1; c.alu_imm = 1'b1; end
      OP_LUI, OP_AUIPC: begin c.reg_write = 1'b1; c.alu_imm = 1'b1; end
      default:          c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file, two async read ports, one write port.
// DECODE_WB_BYPASS_EN forwards a same-cycle write-back onto the read ports.
module decode_regfile
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk_i,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int AW = (NREGS == 16) ? 4 : 5;

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   wa, ra1, ra2;

  assign wa  = waddr[AW-1:0];
  assign ra1 = raddr1[AW-1:0];
  assign ra2 = raddr2[AW-1:0];

  always_ff @(posedge clk_i) begin
    if (we && (wa != '0)) regs[wa] <= wdata;
  end

  always_comb begin
    rdata1 = (ra1 == '0) ? '0 : regs[ra1];
    rdata2 = (ra2 == '0) ? '0 : regs[ra2];
`ifdef DECODE_WB_BYPASS_EN
    if (we && (ra1 != '0) && (ra1 == wa)) rdata1 = wdata;
    if (we && (ra2 != '0) && (ra2 == wa)) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, load-use stall, branch/JAL resolution and the ID/EX register.
// Optional same-cycle write-back bypass in the register file: DECODE_WB_BYPASS_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            ex_load_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_ready_i,
  output logic            id_valid_o,
  output ctrl_t           id_ctrl_o,
  output logic [XLEN-1:0] id_rs1_data_o,
  output logic [XLEN-1:0] id_rs2_data_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [4:0]      id_rd_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam int AW = (NREGS == 16) ? 4 : 5;

  state_e state_q, state_d;

  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [4:0]             rs1, rs2, rd;
  logic [XLEN-1:0]        rs1_val, rs2_val, imm_x, target;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  ctrl_t                  ctrl_dec;
  logic                   hit1, hit2, load_use, stall, idex_free;
  logic                   accept, take, br_cond, redirect;

  logic                   vld_p1;
  ctrl_t                  ctrl_p1;
  logic [XLEN-1:0]        rs1_p1, rs2_p1, imm_p1, pc_p1;
  logic [4:0]             rd_p1;

  assign opcode = if_instr_i[6:0];
  assign funct3 = if_instr_i[14:12];
  assign rs1    = if_instr_i[19:15];
  assign rs2    = if_instr_i[24:20];
  assign rd     = if_instr_i[11:7];

  decode_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk_i  (clk_i),
    .we     (wb_en_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  assign ctrl_dec = decode_ctrl(if_instr_i);
  assign imm_x    = XLEN'(signed'(imm32(if_instr_i)));
  assign target   = if_pc_i + imm_x;
  assign rs1_s    = rs1_val;
  assign rs2_s    = rs2_val;

  // Only source fields the opcode really uses can create a load-use hazard.
  assign hit1     = reads_rs1(opcode) && (ex_rd_i[AW-1:0] == rs1[AW-1:0]);
  assign hit2     = reads_rs2(opcode) && (ex_rd_i[AW-1:0] == rs2[AW-1:0]);
  assign load_use = ex_load_i && (ex_rd_i[AW-1:0] != '0) && (hit1 || hit2);
  assign stall    = (state_q == ST_RUN) && if_valid_i && load_use;

  assign idex_free  = !vld_p1 || ex_ready_i;
  assign if_ready_o = !rst_i && !stall && idex_free;
  assign accept     = if_valid_i && if_ready_o;
  assign take       = accept && (state_q != ST_FLUSH);

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (rs1_val == rs2_val);
      F3_BNE:  br_cond = (rs1_val != rs2_val);
      F3_BLT:  br_cond = (rs1_s < rs2_s);
      F3_BGE:  br_cond = (rs1_s >= rs2_s);
      F3_BLTU: br_cond = (rs1_val < rs2_val);
      F3_BGEU: br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign redirect      = take && (((opcode == OP_BRANCH) && br_cond) || (opcode == OP_JAL));
  assign redirect_o    = redirect;
  assign redirect_pc_o = redirect ? target : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // A blocked flush cycle keeps waiting so the wrong-path word is still dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (stall && idex_free) state_d = ST_STALL;
        else if (redirect)      state_d = ST_FLUSH;
      end
      ST_STALL: state_d = redirect ? ST_FLUSH : ST_RUN;
      ST_FLUSH: if (!if_valid_i || if_ready_o) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // ID/EX boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      imm_p1  <= '0;
      pc_p1   <= '0;
      rd_p1   <= '0;
    end else if (idex_free) begin
      vld_p1  <= take;
      ctrl_p1 <= take ? ctrl_dec : CTRL_NOP;
      if (take) begin
        rs1_p1 <= rs1_val;
        rs2_p1 <= rs2_val;
        imm_p1 <= imm_x;
        pc_p1  <= if_pc_i;
        rd_p1  <= ctrl_dec.reg_write ? rd : 5'd0;
      end
    end
  end

  assign id_valid_o    = vld_p1;
  assign id_ctrl_o     = ctrl_p1;
  assign id_rs1_data_o = rs1_p1;
  assign id_rs2_data_o = rs2_p1;
  assign id_imm_o      = imm_p1;
  assign id_pc_o       = pc_p1;
  assign id_rd_o       = rd_p1;

endmodule
